dac_cfg: RTL and testbench

SPI configuration master for the DAC (AD9957-style serial port), clocked by the configuration clock. It arbitrates three request sources onto one 4-wire SPI link:
- single register writes from the MIF,
- register read-backs,
- per-time-frame profile reloads.

After writes it generates the DAC IO_UPDATE pulse. It double-buffers the DAC profile select so frame data goes live only on IO_UPDATE.

---
 rtl/dac_cfg.sv | 347 ++++++++++++++++++++++++++++++++++
 tb/tb_dac_cfg.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_cfg.sv
// dac_cfg: SPI configuration master for an AD9957-style DAC serial port.
// Arbitrates auto read-back, time-frame profile reloads, register writes and
// register reads onto one 4-wire link, then issues IO_UPDATE after writes.
// Optional build macro: DAC_DEBUG_EN exposes internal state on debug_signal.
module dac_cfg #(
    parameter int unsigned SCLK_DIV     = 2,
    parameter logic [7:0]  TF_BASE_ADDR = 8'h0E,
    parameter int unsigned IOUP_WIDTH   = 4
) (
    input  logic        cfg_spi_clk,
    input  logic        cfg_rst_in,
    input  logic        dac_sync_clk,
    input  logic        mif_dac_spi_red,
    input  logic        time_frame_stat,
    input  logic [31:0] time_frame_data,
    output logic [2:0]  dac_profile_sel,
    input  logic        spi_rd_stat,
    input  logic        spi_rd_en,
    input  logic        dac_spi_start,
    output logic        dac_spi_clk,
    output logic        dac_spi_cs,
    output logic        dac_spi_sdi,
    input  logic        dac_spi_sdo,
    output logic        dac_io_updte,
    input  logic        spi_single_en,
    input  logic        dac_cfg_valid,
    input  logic [7:0]  dac_cfg_addr,
    input  logic [31:0] dac_cfg_data,
    output logic [31:0] dac_rd_parameter,
    output logic        dac_rd_valid,
    output logic        dac_spi_end,
    input  logic [31:0] mif_dac_ioup_time,
    input  logic        dac_stat,
    output logic [63:0] debug_signal
);

    localparam int unsigned     DivW     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast  = DivW'(SCLK_DIV - 1);
    localparam logic [31:0]     IoupLast = 32'(IOUP_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLoad     = 3'd1,
        StShift    = 3'd2,
        StEnd      = 3'd3,
        StIoupWait = 3'd4,
        StIoup     = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic              cs_q, cs_d, sclk_q, sclk_d, sdi_q, sdi_d, io_q, io_d;
    logic [2:0]        prof_q, prof_d;
    logic [31:0]       rd_param_q, rd_param_d;
    logic              rd_valid_q, rd_valid_d, spi_end_q, spi_end_d;
    logic [39:0]       shreg_q, shreg_d;
    logic [31:0]       rx_q, rx_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic [31:0]       wcnt_q, wcnt_d;
    logic [7:0]        cur_addr_q, cur_addr_d;
    logic [31:0]       cur_data_q, cur_data_d;
    logic              cur_rd_q, cur_rd_d, cur_tf_q, cur_tf_d;
    logic [2:0]        cur_prof_q, cur_prof_d;
    logic              tf_pend_q, tf_pend_d;
    logic [31:0]       tf_data_q, tf_data_d;
    logic [2:0]        tf_prof_q, tf_prof_d;
    logic              wr_pend_q, wr_pend_d;
    logic [7:0]        wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              stg_vld_q, stg_vld_d;
    logic [7:0]        stg_addr_q, stg_addr_d;
    logic [31:0]       stg_data_q, stg_data_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        rd_addr_q, rd_addr_d;
    logic              rb_pend_q, rb_pend_d;
    logic [7:0]        rb_addr_q, rb_addr_d;

    // Launch selection (combinational helpers)
    logic              go, n_rd, n_tf;
    logic [7:0]        n_addr;
    logic [31:0]       n_data;
    logic [39:0]       frame;

    // State register with synchronous reset; reset aborts any transfer with CS high
    always_ff @(posedge cfg_spi_clk) begin
        if (cfg_rst_in) begin
            state_q    <= StIdle;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            sdi_q      <= 1'b0;
            io_q       <= 1'b0;
            prof_q     <= 3'd0;
            rd_param_q <= 32'd0;
            rd_valid_q <= 1'b0;
            spi_end_q  <= 1'b0;
            shreg_q    <= 40'd0;
            rx_q       <= 32'd0;
            bit_cnt_q  <= 6'd0;
            div_cnt_q  <= '0;
            wcnt_q     <= 32'd0;
            cur_addr_q <= 8'd0;
            cur_data_q <= 32'd0;
            cur_rd_q   <= 1'b0;
            cur_tf_q   <= 1'b0;
            cur_prof_q <= 3'd0;
            tf_pend_q  <= 1'b0;
            tf_data_q  <= 32'd0;
            tf_prof_q  <= 3'd0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 32'd0;
            stg_vld_q  <= 1'b0;
            stg_addr_q <= 8'd0;
            stg_data_q <= 32'd0;
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= 8'd0;
            rb_pend_q  <= 1'b0;
            rb_addr_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            sdi_q      <= sdi_d;
            io_q       <= io_d;
            prof_q     <= prof_d;
            rd_param_q <= rd_param_d;
            rd_valid_q <= rd_valid_d;
            spi_end_q  <= spi_end_d;
            shreg_q    <= shreg_d;
            rx_q       <= rx_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            wcnt_q     <= wcnt_d;
            cur_addr_q <= cur_addr_d;
            cur_data_q <= cur_data_d;
            cur_rd_q   <= cur_rd_d;
            cur_tf_q   <= cur_tf_d;
            cur_prof_q <= cur_prof_d;
            tf_pend_q  <= tf_pend_d;
            tf_data_q  <= tf_data_d;
            tf_prof_q  <= tf_prof_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            stg_vld_q  <= stg_vld_d;
            stg_addr_q <= stg_addr_d;
            stg_data_q <= stg_data_d;
            rd_pend_q  <= rd_pend_d;
            rd_addr_q  <= rd_addr_d;
            rb_pend_q  <= rb_pend_d;
            rb_addr_q  <= rb_addr_d;
        end
    end

    // Next-state: arbitration, SPI sequencing, IO_UPDATE timing and request capture
    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        sdi_d      = sdi_q;
        io_d       = io_q;
        prof_d     = prof_q;
        rd_param_d = rd_param_q;
        rd_valid_d = 1'b0;
        spi_end_d  = 1'b0;
        shreg_d    = shreg_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        wcnt_d     = wcnt_q;
        cur_addr_d = cur_addr_q;
        cur_data_d = cur_data_q;
        cur_rd_d   = cur_rd_q;
        cur_tf_d   = cur_tf_q;
        cur_prof_d = cur_prof_q;
        tf_pend_d  = tf_pend_q;
        tf_data_d  = tf_data_q;
        tf_prof_d  = tf_prof_q;
        wr_pend_d  = wr_pend_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        stg_vld_d  = stg_vld_q;
        stg_addr_d = stg_addr_q;
        stg_data_d = stg_data_q;
        rd_pend_d  = rd_pend_q;
        rd_addr_d  = rd_addr_q;
        rb_pend_d  = rb_pend_q;
        rb_addr_d  = rb_addr_q;
        go         = 1'b0;
        n_rd       = 1'b0;
        n_tf       = 1'b0;
        n_addr     = 8'd0;
        n_data     = 32'd0;
        frame      = 40'd0;

        unique case (state_q)
            StIdle: begin
                // Auto read-back first, then TF > WR > RD
                if (rb_pend_q) begin
                    go = 1'b1; n_rd = 1'b1; n_addr = rb_addr_q; rb_pend_d = 1'b0;
                end else if (tf_pend_q) begin
                    go = 1'b1; n_tf = 1'b1; n_data = tf_data_q; tf_pend_d = 1'b0;
                    n_addr = TF_BASE_ADDR + {5'd0, tf_prof_q};
                end else if (wr_pend_q) begin
                    go = 1'b1; n_addr = wr_addr_q; n_data = wr_data_q; wr_pend_d = 1'b0;
                end else if (rd_pend_q) begin
                    go = 1'b1; n_rd = 1'b1; n_addr = rd_addr_q; rd_pend_d = 1'b0;
                end
                frame = {n_rd, n_addr[6:0], (n_rd ? 32'd0 : n_data)};
                if (go) begin
                    cur_addr_d = n_addr;
                    cur_data_d = n_data;
                    cur_rd_d   = n_rd;
                    cur_tf_d   = n_tf;
                    cur_prof_d = tf_prof_q;
                    shreg_d    = frame;
                    sdi_d      = frame[39];
                    cs_d       = 1'b0;
                    sclk_d     = 1'b0;
                    div_cnt_d  = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b1;
                    bit_cnt_d = 6'd0;
                    rx_d      = {rx_q[30:0], dac_spi_sdo};
                    state_d   = StShift;
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StShift: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    if (sclk_q) begin
                        // Falling edge: present next bit, data phase ends with SDI low
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[38:0], 1'b0};
                        sdi_d   = (bit_cnt_q == 6'd39) ? 1'b0 : shreg_q[38];
                    end else if (bit_cnt_q == 6'd39) begin
                        state_d = StEnd;
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        rx_d      = {rx_q[30:0], dac_spi_sdo};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StEnd: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    cs_d      = 1'b1;
                    spi_end_d = 1'b1;
                    if (cur_rd_q) begin
                        rd_param_d = rx_q;
                        rd_valid_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        wcnt_d  = 32'd0;
                        state_d = StIoupWait;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StIoupWait: begin
                if (wcnt_q >= mif_dac_ioup_time) begin
                    wcnt_d  = 32'd0;
                    io_d    = 1'b1;
                    state_d = StIoup;
                    if (cur_tf_q) begin
                        prof_d = cur_prof_q;
                    end
                end else begin
                    wcnt_d = wcnt_q + 32'd1;
                end
            end
            StIoup: begin
                if (wcnt_q == IoupLast) begin
                    io_d    = 1'b0;
                    state_d = StIdle;
                    if (mif_dac_spi_red) begin
                        rb_pend_d = 1'b1;
                        rb_addr_d = cur_addr_q;
                    end
                end else begin
                    wcnt_d = wcnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // New requests win over a same-cycle grant so they are never lost
        if (time_frame_stat) begin
            tf_pend_d = 1'b1;
            tf_data_d = time_frame_data;
            tf_prof_d = prof_q + 3'd1;
        end
        if (dac_spi_start && stg_vld_q) begin
            wr_pend_d = 1'b1;
            wr_addr_d = stg_addr_q;
            wr_data_d = stg_data_q;
            stg_vld_d = 1'b0;
        end
        if (dac_cfg_valid) begin
            if (spi_single_en) begin
                wr_pend_d = 1'b1;
                wr_addr_d = dac_cfg_addr;
                wr_data_d = dac_cfg_data;
            end else begin
                stg_vld_d  = 1'b1;
                stg_addr_d = dac_cfg_addr;
                stg_data_d = dac_cfg_data;
            end
        end
        if (spi_rd_stat && spi_rd_en) begin
            rd_pend_d = 1'b1;
            rd_addr_d = dac_cfg_addr;
        end
    end

    assign dac_profile_sel  = prof_q;
    assign dac_spi_clk      = sclk_q;
    assign dac_spi_cs       = cs_q;
    assign dac_spi_sdi      = sdi_q;
    assign dac_io_updte     = io_q;
    assign dac_rd_parameter = rd_param_q;
    assign dac_rd_valid     = rd_valid_q;
    assign dac_spi_end      = spi_end_q;

    // Pins kept for compatibility and debug-only state
    logic unused_pins;
    assign unused_pins = ^{dac_sync_clk, dac_stat, cur_data_q, cur_addr_q[7]};

`ifdef DAC_DEBUG_EN
    assign debug_signal = {cur_data_q, cur_addr_q, 2'b00, bit_cnt_q, 5'b00000, prof_q,
                           dac_stat, dac_spi_sdo, sdi_q, sclk_q, cs_q, state_q};
`else
    assign debug_signal = 64'd0;
`endif

endmodule

// File: tb/tb_dac_cfg.sv
// Scoreboard bench for dac_cfg: stimulus pushes expected frames, a monitor
// decodes each SPI transaction off the pins and compares.
module tb_dac_cfg;

    localparam int unsigned SD = 2;
    localparam int unsigned IW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync_clk = 1'b0;
    logic        spi_red = 1'b0;
    logic        tf_stat = 1'b0;
    logic [31:0] tf_data = 32'd0;
    logic [2:0]  prof_sel;
    logic        rd_stat = 1'b0;
    logic        rd_en = 1'b0;
    logic        spi_start = 1'b0;
    logic        sclk, cs, sdi;
    logic        sdo = 1'b0;
    logic        io;
    logic        single_en = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_addr = 8'd0;
    logic [31:0] cfg_data = 32'd0;
    logic [31:0] rd_param;
    logic        rd_valid, spi_end;
    logic [31:0] ioup_time = 32'd0;
    logic        stat = 1'b0;
    logic [63:0] dbg;

    always #5 clk = ~clk;

    dac_cfg #(.SCLK_DIV(SD), .TF_BASE_ADDR(8'h0E), .IOUP_WIDTH(IW)) dut (
        .cfg_spi_clk      (clk),
        .cfg_rst_in       (rst),
        .dac_sync_clk     (sync_clk),
        .mif_dac_spi_red  (spi_red),
        .time_frame_stat  (tf_stat),
        .time_frame_data  (tf_data),
        .dac_profile_sel  (prof_sel),
        .spi_rd_stat      (rd_stat),
        .spi_rd_en        (rd_en),
        .dac_spi_start    (spi_start),
        .dac_spi_clk      (sclk),
        .dac_spi_cs       (cs),
        .dac_spi_sdi      (sdi),
        .dac_spi_sdo      (sdo),
        .dac_io_updte     (io),
        .spi_single_en    (single_en),
        .dac_cfg_valid    (cfg_valid),
        .dac_cfg_addr     (cfg_addr),
        .dac_cfg_data     (cfg_data),
        .dac_rd_parameter (rd_param),
        .dac_rd_valid     (rd_valid),
        .dac_spi_end      (spi_end),
        .mif_dac_ioup_time(ioup_time),
        .dac_stat         (stat),
        .debug_signal     (dbg)
    );

    typedef struct {
        logic [39:0] frame;
        bit          is_rd;
        bit          abort;
        logic [31:0] rd_word;
        int          ioup;
        logic [2:0]  prof_before;
        logic [2:0]  prof_after;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_busy = 1'b0;
    logic [2:0]  exp_prof = 3'd0;
    int          exp_io = 0;
    int          cs_falls = 0;
    int          io_rises = 0;
    logic        cs_p = 1'b1;
    logic        io_p = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d, input int t,
                           input bit tf, input logic [2:0] tgt);
        exp_t e;
        e.frame = {1'b0, a[6:0], d};
        e.is_rd = 1'b0;
        e.abort = 1'b0;
        e.rd_word = 32'd0;
        e.ioup = t;
        e.prof_before = exp_prof;
        if (tf) exp_prof = tgt;
        e.prof_after = exp_prof;
        exp_io++;
        sb.push_back(e);
    endtask

    task automatic push_rd(input logic [7:0] a, input logic [31:0] w);
        exp_t e;
        e.frame = {1'b1, a[6:0], 32'd0};
        e.is_rd = 1'b1;
        e.abort = 1'b0;
        e.rd_word = w;
        e.ioup = 0;
        e.prof_before = exp_prof;
        e.prof_after = exp_prof;
        sb.push_back(e);
    endtask

    task automatic push_abort();
        exp_t e;
        e.frame = 40'd0;
        e.is_rd = 1'b0;
        e.abort = 1'b1;
        e.rd_word = 32'd0;
        e.ioup = 0;
        e.prof_before = exp_prof;
        e.prof_after = exp_prof;
        sb.push_back(e);
    endtask

    function automatic logic sdo_bit(input exp_t e, input int n);
        if (n >= 8 && n < 40) return e.rd_word[39-n];
        return 1'b0;
    endfunction

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || mon_busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 64'(t >= 5000), 64'd0);
        repeat (5) @(negedge clk);
    endtask

    // Edge counters for activity checks
    always @(negedge clk) begin
        cs_p <= cs;
        io_p <= io;
        if (cs_p === 1'b1 && cs === 1'b0) cs_falls <= cs_falls + 1;
        if (io_p === 1'b0 && io === 1'b1) io_rises <= io_rises + 1;
    end

    // Monitor: decode each CS-low window, act as SDO slave, compare to scoreboard
    initial begin : monitor
        exp_t        e;
        logic [39:0] fr;
        int          cyc, nr, k, w;
        logic        ps;
        forever begin
            @(negedge clk);
            if (!mon_busy && cs === 1'b0 && !rst) begin
                mon_busy = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_frame", 64'd1, 64'd0);
                    e.abort = 1'b1;
                    e.rd_word = 32'd0;
                end else begin
                    e = sb.pop_front();
                end
                fr = 40'd0; cyc = 1; nr = 0; ps = sclk;
                sdo = sdo_bit(e, 0);
                while (cyc < 1000) begin
                    @(negedge clk);
                    if (cs !== 1'b0) break;
                    cyc++;
                    if (!ps && sclk) begin
                        fr = {fr[38:0], sdi};
                        nr++;
                    end
                    if (ps && !sclk) sdo = sdo_bit(e, nr);
                    ps = sclk;
                end
                if (e.abort) begin
                    check("abort_no_end", 64'(spi_end), 64'd0);
                end else begin
                    check("spi_end", 64'(spi_end), 64'd1);
                    check("frame", 64'(fr), 64'(e.frame));
                    check("cs_low_cycles", 64'(cyc), 64'(82 * SD));
                    check("sclk_rises", 64'(nr), 64'd40);
                    if (e.is_rd) begin
                        check("rd_valid", 64'(rd_valid), 64'd1);
                        check("rd_data", 64'(rd_param), 64'(e.rd_word));
                        check("rd_no_ioup", 64'(io), 64'd0);
                    end else begin
                        check("wr_no_rd_valid", 64'(rd_valid), 64'd0);
                        check("profile_hold", 64'(prof_sel), 64'(e.prof_before));
                        k = 0;
                        while (io !== 1'b1 && k < 300) begin
                            @(negedge clk);
                            k++;
                        end
                        check("ioup_delay", 64'(k), 64'(e.ioup + 1));
                        check("profile_at_ioup", 64'(prof_sel), 64'(e.prof_after));
                        w = 0;
                        while (io === 1'b1 && w < 100) begin
                            w++;
                            @(negedge clk);
                        end
                        check("ioup_width", 64'(w), 64'(IW));
                    end
                end
                sdo = 1'b0;
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int saved, t;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cs", 64'(cs), 64'd1);
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_sdi", 64'(sdi), 64'd0);
        check("rst_prof", 64'(prof_sel), 64'd0);
        check("rst_io", 64'(io), 64'd0);
        check("rst_rd", 64'({rd_param, rd_valid, spi_end}), 64'd0);
        check("rst_debug", dbg, 64'd0);
        repeat (20) @(negedge clk);
        check("idle_no_spi", 64'(cs_falls), 64'd0);

        // Time-frame reload into profile 1
        ioup_time = 32'd0;
        push_wr(8'h0F, 32'h0a0b0c0d, 0, 1'b1, 3'd1);
        tf_data = 32'h0a0b0c0d; tf_stat = 1'b1;
        @(negedge clk); tf_stat = 1'b0;
        wait_idle();

        // Single-mode write with delayed IO_UPDATE
        ioup_time = 32'd10;
        push_wr(8'h01, 32'h12345678, 10, 1'b0, 3'd0);
        cfg_addr = 8'h01; cfg_data = 32'h12345678; cfg_valid = 1'b1;
        @(negedge clk); cfg_valid = 1'b0;
        wait_idle();

        // Register read-back
        push_rd(8'h02, 32'hDEADBEEF);
        rd_en = 1'b1; cfg_addr = 8'h02; rd_stat = 1'b1;
        @(negedge clk); rd_stat = 1'b0;
        wait_idle();

        // Batch mode: staged word waits for dac_spi_start
        single_en = 1'b0; ioup_time = 32'd3;
        saved = cs_falls;
        cfg_addr = 8'h05; cfg_data = 32'hCAFEF00D; cfg_valid = 1'b1;
        @(negedge clk); cfg_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("batch_hold", 64'(cs_falls), 64'(saved));
        push_wr(8'h05, 32'hCAFEF00D, 3, 1'b0, 3'd0);
        spi_start = 1'b1;
        @(negedge clk); spi_start = 1'b0;
        wait_idle();

        // TF and cfg write in the same cycle: TF wins, write follows
        single_en = 1'b1; ioup_time = 32'd0;
        push_wr(8'h10, 32'h11223344, 0, 1'b1, 3'd2);
        push_wr(8'h03, 32'h55AA55AA, 0, 1'b0, 3'd0);
        tf_data = 32'h11223344; tf_stat = 1'b1;
        cfg_addr = 8'h03; cfg_data = 32'h55AA55AA; cfg_valid = 1'b1;
        @(negedge clk); tf_stat = 1'b0; cfg_valid = 1'b0;
        wait_idle();

        // Auto read-back after a write
        spi_red = 1'b1; ioup_time = 32'd2;
        push_wr(8'h07, 32'h01020304, 2, 1'b0, 3'd0);
        push_rd(8'h07, 32'h600DF00D);
        cfg_addr = 8'h07; cfg_data = 32'h01020304; cfg_valid = 1'b1;
        @(negedge clk); cfg_valid = 1'b0;
        wait_idle();
        spi_red = 1'b0;

        // Reset mid-transfer aborts and clears pending requests
        push_abort();
        cfg_addr = 8'h09; cfg_data = 32'h0BADC0DE; cfg_valid = 1'b1;
        @(negedge clk); cfg_valid = 1'b0;
        t = 0;
        while (cs !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("abort_start_timeout", 64'(t >= 100), 64'd0);
        repeat (30) @(negedge clk);
        tf_data = 32'h77777777; tf_stat = 1'b1;
        @(negedge clk); tf_stat = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_prof = 3'd0;
        check("abort_cs", 64'(cs), 64'd1);
        wait_idle();
        saved = cs_falls;
        repeat (60) @(negedge clk);
        check("reset_clears_pending", 64'(cs_falls), 64'(saved));
        check("reset_prof", 64'(prof_sel), 64'd0);
        check("reset_rd_param", 64'(rd_param), 64'd0);
        check("ioup_count", 64'(io_rises), 64'(exp_io));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
